transpose_stream: RTL

Streaming matrix transposer: the sequential counterpart to the flat combinational transpose.
- Accepts N×N elements one per cycle in row-major order over a valid/ready interface.
- Emits them in column-major order (that is, the transpose, row-major) over a second valid/ready interface.
- Double-buffered, so one matrix is written while the previous one drains. Sustains 1 element/cycle.
- Sits between the flattened-matrix producers and the streaming arithmetic datapath.

---
 rtl/transpose_stream_if.sv | 17 +
 rtl/transpose_stream.sv | 100 ++++++++++
 2 files changed

// File: rtl/transpose_stream_if.sv
// Valid/ready stream bundle used on both sides of transpose_stream.
// The frame-end flag 'last' exists only when TRANSPOSE_STREAM_LAST_EN is defined.
interface transpose_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
`ifdef TRANSPOSE_STREAM_LAST_EN
  logic                  last;

  modport master (output valid, output data, output last, input ready);
`else
  modport master (output valid, output data, input ready);
`endif
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/transpose_stream.sv
// Streaming N x N transposer: row-major in, column-major out, two banks ping-pong.
// Optional out_last frame marker: define TRANSPOSE_STREAM_LAST_EN.
module transpose_stream #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  transpose_stream_if.slave  in_bus,
  transpose_stream_if.master out_bus
);
  localparam int NN    = N * N;
  localparam int IDX_W = $clog2(NN);
  localparam int RC_W  = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(N - 1);

  logic [DATA_WIDTH-1:0] bank [2][NN];
  logic [1:0]            full;
  logic [1:0]            full_next;
  logic                  wr_bank;
  logic [IDX_W-1:0]      wr_idx;
  logic                  rd_bank;
  logic [RC_W-1:0]       rd_r;
  logic [RC_W-1:0]       rd_c;
  logic                  in_ready;
  logic                  out_valid;
  logic                  in_fire;
  logic                  out_fire;
  logic                  wr_done;
  logic                  rd_done;
  logic [IDX_W-1:0]      rd_addr;

  // Row r of the output is column r of the stored row-major matrix.
  function automatic logic [IDX_W-1:0] col_major_addr(input logic [RC_W-1:0] r,
                                                      input logic [RC_W-1:0] c);
    return IDX_W'(c) * IDX_W'(N) + IDX_W'(r);
  endfunction

  assign in_ready  = !rst && !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign in_fire   = in_bus.valid && in_ready;
  assign out_fire  = out_valid && out_bus.ready;
  assign wr_done   = in_fire && (wr_idx == IDX_LAST);
  assign rd_done   = out_fire && (rd_r == RC_LAST) && (rd_c == RC_LAST);
  assign rd_addr   = col_major_addr(rd_r, rd_c);

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = out_valid;
  assign out_bus.data  = out_valid ? bank[rd_bank][rd_addr] : '0;
`ifdef TRANSPOSE_STREAM_LAST_EN
  assign out_bus.last  = out_valid && (rd_r == RC_LAST) && (rd_c == RC_LAST);
`endif

  // Completion on one bank and release of the other may coincide; both apply.
  always_comb begin
    full_next = full;
    if (wr_done) full_next[wr_bank] = 1'b1;
    if (rd_done) full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_idx  <= '0;
      rd_bank <= 1'b0;
      rd_r    <= '0;
      rd_c    <= '0;
    end else begin
      full <= full_next;
      if (in_fire) begin
        if (wr_done) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end
      if (out_fire) begin
        if (rd_c == RC_LAST) begin
          rd_c <= '0;
          if (rd_r == RC_LAST) begin
            rd_r    <= '0;
            rd_bank <= ~rd_bank;
          end else begin
            rd_r <= rd_r + RC_W'(1);
          end
        end else begin
          rd_c <= rd_c + RC_W'(1);
        end
      end
    end
  end

  // Element storage carries no reset; only the flags and pointers qualify it.
  always_ff @(posedge clk) begin
    if (in_fire) bank[wr_bank][wr_idx] <= in_bus.data;
  end
endmodule
